prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader
//   Receives a program image as a framed byte stream, writes it word by word
//   into program memory and holds the CPU in reset until the whole image has
//   arrived with a matching checksum.
//
//   Frame: LEN_HI, LEN_LO (word count N, big-endian), N x 4 data bytes
//          (each word MSB first), then one CSUM byte.
//          CSUM is the XOR of all data bytes.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : source presents a byte on in_data
//   in_data    : byte stream data
//   in_ready   : loader accepts a byte this cycle
//   mem_addr   : word address to program memory (BASE_ADDR + word index)
//   mem_wdata  : word to write, held between writes
//   mem_we     : one-cycle write strobe
//   cpu_reset  : high until the load completes successfully
//   done       : load completed with a good checksum
//   err        : load failed on the checksum
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  xor_q, xor_d;

  logic accepting;
  logic accept;

  // Byte acceptance: the loader only listens in the four byte-consuming
  // states, and never during the cycle reset is being sampled.
  always_comb begin
    accepting = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                (state_q == DATA)   || (state_q == CSUM);
    in_ready  = accepting && !reset;
    accept    = in_ready && in_valid;
  end

  // Next-state and datapath update. WRITE always lasts a single cycle and
  // is the only place the word index advances; the word register keeps
  // shifting through the next word, so the write data is captured into its
  // own register so it stays stable between writes.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    xor_d      = xor_q;

    case (state_q)
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          // An empty image goes straight to the checksum byte.
          if ({len_q[15:8], in_data} == 16'h0000) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], in_data};
          xor_d      = xor_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wdata_d = {word_q[23:0], in_data};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        idx_d      = idx_q + 16'd1;
        byte_idx_d = 2'd0;
        if ((idx_q + 16'd1) == len_q) begin
          state_d = CSUM;
        end else begin
          state_d = DATA;
        end
      end
      CSUM: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
          end
        end
      end
      DONE: state_d = DONE;
      ERR:  state_d = ERR;
      default: state_d = LEN_HI;
    endcase
  end

  // State registers. Reset wins over everything, including a frame that is
  // halfway through a word or sitting in WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LEN_HI;
      len_q      <= 16'h0000;
      idx_q      <= 16'h0000;
      byte_idx_q <= 2'd0;
      word_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      xor_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      xor_q      <= xor_d;
    end
  end

  // Output decode. Outputs are gated by reset so that the reset cycle itself
  // already shows the idle values and can never produce a write strobe.
  // The address wraps naturally in 16 bits.
  always_comb begin
    mem_we    = (state_q == WRITE) && !reset;
    mem_addr  = reset ? BASE_ADDR : (BASE_ADDR + idx_q);
    mem_wdata = wdata_q;
    cpu_reset = reset || (state_q != DONE);
    done      = (state_q == DONE) && !reset;
    err       = (state_q == ERR) && !reset;
  end

endmodule
